// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - pops an async-read byte FIFO and re-emits fixed-length bursts as a valid/ready stream
//
// Purpose:
//   Waits until the upstream FIFO holds a full burst (BURST_LEN bytes), then pops it
//   through a 2-entry skid buffer onto a valid/ready byte stream. out_last marks the
//   final byte of every burst. The FIFO is never popped while it reports empty.
//
// Optional feature (macro FLUSH_TIMEOUT_EN):
//   When defined, a partial burst that sits untouched in the FIFO for TIMEOUT cycles
//   is flushed as a short burst (out_last on its final byte). When undefined, partial
//   bursts wait indefinitely.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   fifo_count  in   FIFO occupancy
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO read data, valid in the same cycle as fifo_ren
//   fifo_ren    out  FIFO pop strobe
//   out_valid   out  stream byte valid
//   out_ready   in   sink accepts the byte
//   out_data    out  stream byte
//   out_last    out  final byte of a burst
//   busy        out  streaming a burst or skid buffer holds data
//   burst_cnt   out  completed bursts, 8-bit wrapping

module fifo_burst_drain #(
    parameter int DATA_W    = 8,
    parameter int MAX_DATA  = 16,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_DATA+1)-1:0]   fifo_count,
    input  logic                            fifo_empty,
    input  logic [DATA_W-1:0]               fifo_rdata,
    output logic                            fifo_ren,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic [7:0]                      burst_cnt
);

    localparam int CNT_W = $clog2(MAX_DATA + 1);
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    // Elaboration-time guard on parameter ranges.
    if (BURST_LEN < 1 || BURST_LEN > MAX_DATA || TIMEOUT < 2 || TIMEOUT > 128) begin : g_param_check
        $error("fifo_burst_drain: BURST_LEN or TIMEOUT out of range");
    end

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;

    // Two-entry skid buffer, circular with one-bit pointers.
    logic [DATA_W-1:0]  skid_data_q [2];
    logic               skid_last_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         occ_q, occ_d;

    logic [7:0]         burst_cnt_q;

    logic               push;
    logic               pop;
    logic               head_last;
    logic               flush_fire;

    // The pop strobe depends only on registered state and the FIFO flag, never on
    // out_ready; the skid buffer absorbs the one-cycle sink reaction.
    assign fifo_ren  = (state_q == ST_STREAM) && !fifo_empty && (occ_q != 2'd2);
    assign push      = fifo_ren;
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head_last = skid_last_q[rd_ptr_q];

    // Stale entries are masked so the stream reads all-zero while idle.
    assign out_data  = out_valid ? skid_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && head_last;
    assign busy      = (state_q != ST_WAIT) || out_valid;
    assign burst_cnt = burst_cnt_q;

    assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

`ifdef FLUSH_TIMEOUT_EN
    localparam logic [6:0] TIMEOUT_M1 = 7'(TIMEOUT - 1);

    logic [6:0]         timer_q, timer_d;
    logic [CNT_W-1:0]   prev_count_q;

    // The timer only reaches its terminal value while a non-empty partial burst has
    // been stable, so the count check here merely guards against a FIFO glitch.
    assign flush_fire = (timer_q == TIMEOUT_M1) && (fifo_count != '0);

    always_comb begin
        timer_d = timer_q + 7'd1;
        if ((state_q != ST_WAIT) || (fifo_count == '0) || (fifo_count >= BURST_LEN_C) ||
            (fifo_count != prev_count_q) || flush_fire) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            prev_count_q <= '0;
        end else begin
            timer_q      <= timer_d;
            prev_count_q <= fifo_count;
        end
    end
`else
    assign flush_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_WAIT: begin
                if (fifo_count >= BURST_LEN_C) begin
                    state_d     = ST_STREAM;
                    remaining_d = BURST_LEN_C;
                end else if (flush_fire) begin
                    // Short burst: drain exactly what is present.
                    state_d     = ST_STREAM;
                    remaining_d = fifo_count;
                end
            end
            ST_STREAM: begin
                if (fifo_ren) begin
                    remaining_d = remaining_q - ONE_C;
                    if (remaining_q == ONE_C) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d     = ST_WAIT;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT;
            remaining_q    <= '0;
            occ_q          <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_last_q[0] <= 1'b0;
            skid_last_q[1] <= 1'b0;
            burst_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            occ_q       <= occ_d;
            if (push) begin
                skid_data_q[wr_ptr_q] <= fifo_rdata;
                skid_last_q[wr_ptr_q] <= (remaining_q == ONE_C);
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                if (head_last) begin
                    burst_cnt_q <= burst_cnt_q + 8'd1;
                end
            end
        end
    end

endmodule
